// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: hazard FSM states, forward-select encoding
// and the register-source field positions inside an instruction word.
package rv32_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one source register; a result still being loaded
// in EX is not forwardable, so the MEM copy (if any) is used instead.
module hazard_fwd_sel
  import rv32_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_w_en,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_w_en,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_REG;
    if ((rs != 5'd0) && ex_reg_w_en && (ex_rd == rs) && !ex_is_load) begin
      fwd_sel = FWD_EX;
    end else if ((rs != 5'd0) && mem_reg_w_en && (mem_rd == rs)) begin
      fwd_sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: forwarding, load-use and mul/div stalls, branch
// flush. Define HAZARD_PERF_CNT_EN to add saturating stall/flush cycle counters.
module hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dec_ins,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_w_en,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_w_en,
  input  logic        mc_start,
  input  logic        mc_done,
  input  logic        br_taken,
  output logic [1:0]  fwd_sel1,
  output logic [1:0]  fwd_sel2,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        mc_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(MC_TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

  logic [4:0]    rs1, rs2;
  logic [1:0]    sel1, sel2;
  logic          load_use;
  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          stall, bubble, flush;
  logic          unused_ins;

  assign rs1        = dec_ins[RS1_MSB:RS1_LSB];
  assign rs2        = dec_ins[RS2_MSB:RS2_LSB];
  assign unused_ins = ^{dec_ins[31:RS2_MSB+1], dec_ins[RS1_LSB-1:0]};

  hazard_fwd_sel u_fwd1 (
    .rs           (rs1),
    .ex_rd        (ex_rd),
    .ex_reg_w_en  (ex_reg_w_en),
    .ex_is_load   (ex_is_load),
    .mem_rd       (mem_rd),
    .mem_reg_w_en (mem_reg_w_en),
    .fwd_sel      (sel1)
  );

  hazard_fwd_sel u_fwd2 (
    .rs           (rs2),
    .ex_rd        (ex_rd),
    .ex_reg_w_en  (ex_reg_w_en),
    .ex_is_load   (ex_is_load),
    .mem_rd       (mem_rd),
    .mem_reg_w_en (mem_reg_w_en),
    .fwd_sel      (sel2)
  );

  assign load_use = ex_is_load && ex_reg_w_en && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));

  // Priority: br_taken > mc_done > mc_start > load-use; a taken branch flushes
  // in the same cycle, so stall and flush can never coincide.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (br_taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
          flush   = 1'b1;
          bubble  = 1'b1;
        end else if (mc_start) begin
          state_d = MC_WAIT;
          tmo_d   = '0;
        end else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      MC_WAIT: begin
        if (br_taken) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
          flush   = 1'b1;
          bubble  = 1'b1;
        end else if (!mc_done) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = RUN;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (br_taken) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though some are combinational.
  assign fwd_sel1  = rst_n ? sel1 : FWD_REG;
  assign fwd_sel2  = rst_n ? sel2 : FWD_REG;
  assign stall_if  = rst_n & stall;
  assign stall_id  = rst_n & stall;
  assign bubble_ex = rst_n & bubble;
  assign flush_id  = rst_n & flush;
  assign mc_err    = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] pstall_q, pflush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      if (stall_id && (pstall_q != '1)) pstall_q <= pstall_q + 1'b1;
      if (flush_id && (pflush_q != '1)) pflush_q <= pflush_q + 1'b1;
    end
  end

  assign perf_stall = pstall_q;
  assign perf_flush = pflush_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
